gpio_packet_deserializer: RTL and testbench
===========================================

Name: gpio_packet_deserializer

Overview:
- Upstream stage of the SRAM test-chip control logic. Receives a command packet bit-serially over three GPIO pins (sclk, cs_n, sdi), assembles it and presents it to the control logic's GPIO packet input.
- Also shifts the captured SRAM read data back out on a GPIO pin (sdo) for off-chip checking.
- GPIO pins are asynchronous to the system clock. All logic runs on `clock` only; sclk is sampled, never used as a clock.

Parameters:
- PACKET_BITS, 86, width of the assembled command packet.
- DATA_BITS, 64, width of the SRAM read data shifted back out.
- SYNC_STAGES, 2, synchronizer depth on sclk, cs_n and sdi (minimum 2).

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- gpio_sclk  input  1  serial clock from pad, asynchronous.
- gpio_cs_n  input  1  frame select from pad, active low, asynchronous.
- gpio_sdi  input  1  serial data in, MSB first.
- gpio_sdo  output  1  serial readback data out, MSB first.
- gpio_sdo_oeb  output  1  pad output-enable bar; 0 while cs_n is low (synchronized), else 1.
- packet  output  PACKET_BITS  last complete packet, held until the next complete frame.
- packet_valid  output  1  one-cycle pulse when `packet` updates.
- sram_data  input  DATA_BITS  read data from the control logic.
- sram_data_valid  input  1  one-cycle strobe; loads the readback shift register.
- frame_error  output  1  sticky; short or long frame seen; cleared by next cs_n falling edge.

Behaviour:
- Reset values: packet=0, packet_valid=0, gpio_sdo=0, gpio_sdo_oeb=1, frame_error=0, FSM=IDLE, bit counter=0.
- Synchronizers: sclk, cs_n and sdi each pass through SYNC_STAGES flops (reset to sclk=0, cs_n=1, sdi=0).
  - Edge detect uses one further flop on synced sclk: rise = sync & ~prev; fall = ~sync & prev.
  - sdi is sampled from the synchronized value in the same cycle rise is detected.
- FSM states: IDLE, SHIFT, DONE, ERR.
  - IDLE: on synced cs_n falling, clear bit counter and frame_error, go to SHIFT.
  - SHIFT, rise with cs_n low: shift register <= {shreg[PACKET_BITS-2:0], sdi}; counter++.
  - SHIFT, cs_n rises with counter==PACKET_BITS: go to DONE.
  - SHIFT, cs_n rises with counter!=PACKET_BITS: set frame_error, go to ERR; packet is not updated.
  - SHIFT, rise when counter==PACKET_BITS already: the extra bit is ignored and the counter saturates. A flag marks the frame long, so it ends in ERR.
  - DONE: packet <= shreg, packet_valid=1 for exactly one cycle, return to IDLE. Latency from the synced cs_n rise to packet_valid is 1 clock.
  - ERR: return to IDLE next cycle.
- cs_n edge and sclk rise in the same cycle: the cs_n rise wins and the sclk edge is discarded. The cs_n fall takes effect before any shift, so a rise in the fall cycle is ignored.
- Readback path:
  - sram_data_valid loads the DATA_BITS readback register.
  - gpio_sdo = readback MSB, registered.
  - On each synced sclk fall while cs_n is low, the register shifts left and fills 0.
  - If sram_data_valid and an sclk fall coincide, the load wins.
  - After DATA_BITS shifts, sdo holds 0.
- Minimum sclk half-period: SYNC_STAGES+2 clock cycles; faster sclk is unsupported.
- reset_n asserted mid-frame: everything returns to reset values immediately. A frame in progress is lost; no packet_valid is produced.

Optional Feature:
- Macro: GPIO_PACKET_PARITY_EN.
- Defined:
  - A frame is PACKET_BITS+1 bits; the final bit is even parity over the packet bits.
  - A correct-length frame with a parity mismatch goes to ERR, sets frame_error and does not update the packet.
  - A correct-length frame with a parity match goes to DONE.
- Undefined: no parity bit; frame length is PACKET_BITS exactly.

Test Plan:
- After reset_n release: packet=0, sdo_oeb=1, packet_valid never pulses with cs_n high.
- Full frame: cs_n low, 86 bits of 86'h2A_5555_AAAA_0F0F_F0F0_1234, cs_n high → packet equals that value, one packet_valid pulse, frame_error=0.
- Short frame: 85 bits then cs_n high → no packet_valid, packet keeps its prior value, frame_error=1. Next cs_n fall clears frame_error.
- Long frame: 87 bits → frame_error=1, packet unchanged.
- Readback: sram_data=64'hDEAD_BEEF_0123_4567 with valid strobe, cs_n low, 64 sclk pulses → sdo bit stream reads 64'hDEAD_BEEF_0123_4567 MSB first, then 0.
- reset_n pulsed after 40 bits, then a full 86-bit frame → only the second frame produces packet_valid. With GPIO_PACKET_PARITY_EN, a flipped parity bit → frame_error=1 and no packet_valid.

Source files
------------

// File: rtl/gpio_packet_deserializer.sv
// Bit-serial GPIO command packet receiver with serial readback of SRAM data; all pads are sampled on clock.
// Optional GPIO_PACKET_PARITY_EN appends an even-parity bit to each frame and rejects frames that fail it.
module gpio_packet_deserializer #(
    parameter int PACKET_BITS = 86,
    parameter int DATA_BITS   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   gpio_sclk,
    input  logic                   gpio_cs_n,
    input  logic                   gpio_sdi,
    output logic                   gpio_sdo,
    output logic                   gpio_sdo_oeb,
    output logic [PACKET_BITS-1:0] packet,
    output logic                   packet_valid,
    input  logic [DATA_BITS-1:0]   sram_data,
    input  logic                   sram_data_valid,
    output logic                   frame_error
);

`ifdef GPIO_PACKET_PARITY_EN
    localparam int FRAME_BITS = PACKET_BITS + 1;
`else
    localparam int FRAME_BITS = PACKET_BITS;
`endif
    localparam int              CNT_W     = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] cs_n_sync_reg;
    logic [SYNC_STAGES-1:0] sdi_sync_reg;
    logic                   sclk_prev_reg;
    logic                   cs_n_prev_reg;

    state_t                 state_reg;
    logic [FRAME_BITS-1:0]  shreg_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic                   long_reg;
    logic [PACKET_BITS-1:0] packet_reg;
    logic                   packet_valid_reg;
    logic                   frame_error_reg;
    logic [DATA_BITS-1:0]   readback_reg;

    logic sclk_s, cs_n_s, sdi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic len_ok, frame_ok;

    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync_reg[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync_reg[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign cs_rise   = cs_n_s & ~cs_n_prev_reg;
    assign cs_fall   = ~cs_n_s & cs_n_prev_reg;

    // A frame that overran is flagged by long_reg even though the counter saturated at the right value.
    assign len_ok = (bit_cnt_reg == FRAME_LEN) && !long_reg;
`ifdef GPIO_PACKET_PARITY_EN
    assign frame_ok = len_ok && !(^shreg_reg);
`else
    assign frame_ok = len_ok;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_reg <= '0;
            cs_n_sync_reg <= '1;
            sdi_sync_reg  <= '0;
            sclk_prev_reg <= 1'b0;
            cs_n_prev_reg <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], gpio_sclk};
            cs_n_sync_reg <= {cs_n_sync_reg[SYNC_STAGES-2:0], gpio_cs_n};
            sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], gpio_sdi};
            sclk_prev_reg <= sclk_s;
            cs_n_prev_reg <= cs_n_s;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            shreg_reg        <= '0;
            bit_cnt_reg      <= '0;
            long_reg         <= 1'b0;
            packet_reg       <= '0;
            packet_valid_reg <= 1'b0;
            frame_error_reg  <= 1'b0;
        end else begin
            packet_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt_reg     <= '0;
                        long_reg        <= 1'b0;
                        frame_error_reg <= 1'b0;
                        state_reg       <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs_n rise takes priority over any sclk edge landing in the same cycle.
                    if (cs_rise) begin
                        if (frame_ok) begin
                            packet_reg       <= shreg_reg[FRAME_BITS-1 -: PACKET_BITS];
                            packet_valid_reg <= 1'b1;
                            state_reg        <= DONE;
                        end else begin
                            frame_error_reg <= 1'b1;
                            state_reg       <= ERR;
                        end
                    end else if (sclk_rise && !cs_n_s) begin
                        if (bit_cnt_reg == FRAME_LEN) begin
                            long_reg <= 1'b1;
                        end else begin
                            shreg_reg   <= {shreg_reg[FRAME_BITS-2:0], sdi_s};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                ERR:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Load beats a coincident sclk fall; shifting fills zeros so sdo idles low once drained.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readback_reg <= '0;
        end else if (sram_data_valid) begin
            readback_reg <= sram_data;
        end else if (sclk_fall && !cs_n_s) begin
            readback_reg <= {readback_reg[DATA_BITS-2:0], 1'b0};
        end
    end

    assign gpio_sdo     = readback_reg[DATA_BITS-1];
    assign gpio_sdo_oeb = cs_n_s;
    assign packet       = packet_reg;
    assign packet_valid = packet_valid_reg;
    assign frame_error  = frame_error_reg;

endmodule

// File: tb/tb_gpio_packet_deserializer.sv
// Directed bench for gpio_packet_deserializer: full, short, long, readback, mid-frame reset and parity frames.
module tb_gpio_packet_deserializer;

    localparam int PB   = 86;
    localparam int DB   = 64;
    localparam int HALF = 6;
`ifdef GPIO_PACKET_PARITY_EN
    localparam int FB = PB + 1;
`else
    localparam int FB = PB;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic          sdi = 1'b0;
    logic          sdo, sdo_oeb;
    logic [PB-1:0] packet;
    logic          packet_valid;
    logic [DB-1:0] sram_data = '0;
    logic          sram_data_valid = 1'b0;
    logic          frame_error;

    int n_checks = 0;
    int n_fail   = 0;
    int pv_count = 0;

    logic [PB-1:0] p1 = 86'h2A_5555_AAAA_0F0F_F0F0_1234;
    logic [PB-1:0] p2 = 86'h3F_0123_4567_89AB_CDEF_FEDC;
    logic [PB-1:0] p3 = 86'h15_A5A5_5A5A_C3C3_3C3C_9876;

    gpio_packet_deserializer #(.PACKET_BITS(PB), .DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clock           (clk),
        .reset_n         (rst_n),
        .gpio_sclk       (sclk),
        .gpio_cs_n       (cs_n),
        .gpio_sdi        (sdi),
        .gpio_sdo        (sdo),
        .gpio_sdo_oeb    (sdo_oeb),
        .packet          (packet),
        .packet_valid    (packet_valid),
        .sram_data       (sram_data),
        .sram_data_valid (sram_data_valid),
        .frame_error     (frame_error)
    );

    always #5 clk = ~clk;

    // Counts cycles with packet_valid high, so a stretched pulse shows up as an extra count.
    always @(posedge clk) if (packet_valid === 1'b1) pv_count <= pv_count + 1;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_frame(input logic [PB-1:0] p);
`ifdef GPIO_PACKET_PARITY_EN
        return 128'({p, ^p});
`else
        return 128'(p);
`endif
    endfunction

    task automatic send_bit(input logic b);
        sdi = b;
        wait_clks(HALF);
        sclk = 1'b1;
        wait_clks(HALF);
        sclk = 1'b0;
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        wait_clks(8);
    endtask

    task automatic end_frame();
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(10);
    endtask

    task automatic send_frame(input logic [127:0] v, input int nbits);
        start_frame();
        for (int i = nbits - 1; i >= 0; i--) send_bit(v[i]);
        end_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(20);
        n_checks++; if (packet !== '0) begin n_fail++; $display("FAIL reset_packet got=%h exp=0", packet); end
        n_checks++; if (sdo_oeb !== 1'b1) begin n_fail++; $display("FAIL reset_oeb got=%b exp=1", sdo_oeb); end
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", frame_error); end
        n_checks++; if (pv_count !== 0) begin n_fail++; $display("FAIL reset_pv got=%0d exp=0", pv_count); end
        $display("reset: packet=%h oeb=%b sdo=%b ferr=%b", packet, sdo_oeb, sdo, frame_error);
    endtask

    task automatic test_full_frame();
        int pv0 = pv_count;
        logic [127:0] fv = mk_frame(p1);
        start_frame();
        n_checks++; if (sdo_oeb !== 1'b0) begin n_fail++; $display("FAIL full_oeb_low got=%b exp=0", sdo_oeb); end
        for (int i = FB - 1; i >= 0; i--) send_bit(fv[i]);
        end_frame();
        n_checks++; if (packet !== p1) begin n_fail++; $display("FAIL full_packet got=%h exp=%h", packet, p1); end
        n_checks++; if (pv_count - pv0 !== 1) begin n_fail++; $display("FAIL full_pv got=%0d exp=1", pv_count - pv0); end
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL full_ferr got=%b exp=0", frame_error); end
        n_checks++; if (sdo_oeb !== 1'b1) begin n_fail++; $display("FAIL full_oeb_high got=%b exp=1", sdo_oeb); end
        $display("full frame: packet=%h pulses=%0d ferr=%b", packet, pv_count - pv0, frame_error);
    endtask

    task automatic test_short_frame();
        int pv0 = pv_count;
        logic [127:0] fv = mk_frame(p2);
        send_frame(fv, FB - 1);
        n_checks++; if (pv_count - pv0 !== 0) begin n_fail++; $display("FAIL short_pv got=%0d exp=0", pv_count - pv0); end
        n_checks++; if (packet !== p1) begin n_fail++; $display("FAIL short_packet got=%h exp=%h", packet, p1); end
        n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL short_ferr got=%b exp=1", frame_error); end
        $display("short frame: packet=%h pulses=%0d ferr=%b", packet, pv_count - pv0, frame_error);
    endtask

    task automatic test_back_to_back();
        int pv0 = pv_count;
        logic [127:0] fv = mk_frame(p2);
        start_frame();
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL b2b_ferr_clear got=%b exp=0", frame_error); end
        for (int i = FB - 1; i >= 0; i--) send_bit(fv[i]);
        end_frame();
        n_checks++; if (packet !== p2) begin n_fail++; $display("FAIL b2b_packet got=%h exp=%h", packet, p2); end
        n_checks++; if (pv_count - pv0 !== 1) begin n_fail++; $display("FAIL b2b_pv got=%0d exp=1", pv_count - pv0); end
        $display("recovery frame: packet=%h pulses=%0d ferr=%b", packet, pv_count - pv0, frame_error);
    endtask

    task automatic test_long_frame();
        int pv0 = pv_count;
        logic [127:0] fv = {mk_frame(p3), 1'b1} ;
        send_frame(fv, FB + 1);
        n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL long_ferr got=%b exp=1", frame_error); end
        n_checks++; if (packet !== p2) begin n_fail++; $display("FAIL long_packet got=%h exp=%h", packet, p2); end
        n_checks++; if (pv_count - pv0 !== 0) begin n_fail++; $display("FAIL long_pv got=%0d exp=0", pv_count - pv0); end
        $display("long frame: packet=%h pulses=%0d ferr=%b", packet, pv_count - pv0, frame_error);
    endtask

    task automatic test_readback();
        logic [DB-1:0] exp_word = 64'hDEAD_BEEF_0123_4567;
        logic [DB-1:0] got_word = '0;
        sram_data = exp_word;
        sram_data_valid = 1'b1;
        wait_clks(1);
        sram_data_valid = 1'b0;
        sram_data = '0;
        wait_clks(2);
        start_frame();
        for (int i = 0; i < DB; i++) begin
            sdi = 1'b0;
            wait_clks(HALF);
            got_word = {got_word[DB-2:0], sdo};
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        wait_clks(HALF);
        n_checks++; if (got_word !== exp_word) begin n_fail++; $display("FAIL readback_word got=%h exp=%h", got_word, exp_word); end
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL readback_drained got=%b exp=0", sdo); end
        end_frame();
        n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL readback_ferr got=%b exp=1", frame_error); end
        $display("readback: word=%h sdo_after=%b ferr=%b", got_word, sdo, frame_error);
    endtask

    task automatic test_reset_mid_frame();
        int pv0 = pv_count;
        logic [127:0] fv = mk_frame(p1);
        start_frame();
        for (int i = FB - 1; i >= FB - 40; i--) send_bit(fv[i]);
        rst_n = 1'b0;
        cs_n = 1'b1;
        wait_clks(1);
        n_checks++; if (packet !== '0) begin n_fail++; $display("FAIL midrst_packet got=%h exp=0", packet); end
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr got=%b exp=0", frame_error); end
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(10);
        send_frame(mk_frame(p3), FB);
        n_checks++; if (packet !== p3) begin n_fail++; $display("FAIL midrst_packet2 got=%h exp=%h", packet, p3); end
        n_checks++; if (pv_count - pv0 !== 1) begin n_fail++; $display("FAIL midrst_pv got=%0d exp=1", pv_count - pv0); end
        $display("mid-frame reset: packet=%h pulses=%0d", packet, pv_count - pv0);
    endtask

`ifdef GPIO_PACKET_PARITY_EN
    task automatic test_parity_error();
        int pv0 = pv_count;
        logic [127:0] fv = mk_frame(p1) ^ 128'd1;
        send_frame(fv, FB);
        n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL parity_ferr got=%b exp=1", frame_error); end
        n_checks++; if (pv_count - pv0 !== 0) begin n_fail++; $display("FAIL parity_pv got=%0d exp=0", pv_count - pv0); end
        n_checks++; if (packet !== p3) begin n_fail++; $display("FAIL parity_packet got=%h exp=%h", packet, p3); end
        $display("parity error frame: packet=%h pulses=%0d ferr=%b", packet, pv_count - pv0, frame_error);
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_back_to_back();
        test_long_frame();
        test_readback();
        test_reset_mid_frame();
`ifdef GPIO_PACKET_PARITY_EN
        test_parity_error();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
